// File: rtl/pointer_coord_pkg.sv
// Shared types and defaults for the two-axis debug pointer coordinate generator.
// Optional auto-repeat is enabled by defining POINTER_HOLD_REPEAT_EN.
package pointer_coord_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2
  } step_e;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_X_MAX = 15;
  localparam int DEF_Y_MAX = 15;

  // Opposing step events on the same edge cancel each other.
  function automatic step_e resolve_step(input logic inc_ev, input logic dec_ev);
    step_e s;
    s = STEP_NONE;
    if (inc_ev && !dec_ev) s = STEP_INC;
    else if (dec_ev && !inc_ev) s = STEP_DEC;
    return s;
  endfunction

endpackage

// File: rtl/pointer_coord_gen_axis.sv
// One pointer axis: press edge detect, conflict cancel, bounded wrap/saturate counter.
// With POINTER_HOLD_REPEAT_EN defined, a held request auto-repeats after a delay.
module pointer_axis_counter
  import pointer_coord_pkg::*;
#(
  parameter int W             = 4,
  parameter int MAX           = 15,
  parameter bit WRAP          = 1'b1,
  parameter int REPEAT_DELAY  = 24,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         control_set,
  input  logic         inc_req,
  input  logic         dec_req,
  output logic [W-1:0] coord,
  output logic         moved,
  output logic         bump
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] coord_q, coord_d;
  logic         moved_q, moved_d;
  logic         bump_q, bump_d;
  logic [1:0]   hist_q, hist_d;
  logic         inc_ev, dec_ev;
  step_e        edge_step;
  step_e        step;

  // History resets high so a request held through reset needs a fresh press.
  assign hist_d    = {inc_req, dec_req};
  assign inc_ev    = inc_req & ~hist_q[1];
  assign dec_ev    = dec_req & ~hist_q[0];
  assign edge_step = resolve_step(inc_ev, dec_ev);

`ifdef POINTER_HOLD_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  rpt_state_e   state_q, state_d;
  step_e        dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  step_e        rpt_step;
  logic         held;

  assign held = (dir_q == STEP_INC) ? inc_req : (dir_q == STEP_DEC) ? dec_req : 1'b0;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    rpt_step = STEP_NONE;
    if (control_set || (inc_req && dec_req)) begin
      state_d = RPT_IDLE;
      dir_d   = STEP_NONE;
      cnt_d   = '0;
    end else if (edge_step != STEP_NONE) begin
      state_d = RPT_DELAY;
      dir_d   = edge_step;
      cnt_d   = '0;
    end else if (state_q != RPT_IDLE && !held) begin
      state_d = RPT_IDLE;
      dir_d   = STEP_NONE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RPT_DELAY: begin
          if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            rpt_step = dir_q;
            state_d  = RPT_REPEAT;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            rpt_step = dir_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RPT_IDLE;
      dir_q   <= STEP_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step = (edge_step != STEP_NONE) ? edge_step : rpt_step;
`else
  assign step = edge_step;
`endif

  always_comb begin
    coord_d = coord_q;
    bump_d  = 1'b0;
    if (control_set) begin
      coord_d = '0;
    end else begin
      case (step)
        STEP_INC: begin
          if (coord_q < MAX_V)  coord_d = coord_q + 1'b1;
          else if (WRAP)        coord_d = '0;
          else                  bump_d  = 1'b1;
        end
        STEP_DEC: begin
          if (coord_q != '0)    coord_d = coord_q - 1'b1;
          else if (WRAP)        coord_d = MAX_V;
          else                  bump_d  = 1'b1;
        end
        default: ;
      endcase
    end
    // A clear is not a move, even when it changes the coordinate.
    moved_d = !control_set && (coord_d != coord_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coord_q <= '0;
      moved_q <= 1'b0;
      bump_q  <= 1'b0;
      hist_q  <= 2'b11;
    end else begin
      coord_q <= coord_d;
      moved_q <= moved_d;
      bump_q  <= bump_d;
      hist_q  <= hist_d;
    end
  end

  assign coord = coord_q;
  assign moved = moved_q;
  assign bump  = bump_q;

endmodule

// File: rtl/pointer_coord_gen.sv
// Two-axis debug pointer coordinate generator; one step per press, moved/bump strobes.
// Optional hold-to-repeat is enabled by defining POINTER_HOLD_REPEAT_EN.
module pointer_coord_gen
  import pointer_coord_pkg::*;
#(
  parameter int X_W           = 4,
  parameter int Y_W           = 4,
  parameter int X_MAX         = DEF_X_MAX,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter bit WRAP          = 1'b1,
  parameter int REPEAT_DELAY  = 24,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           control_set,
  input  logic           left,
  input  logic           right,
  input  logic           up,
  input  logic           down,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           moved,
  output logic           bump
);

  logic x_moved, y_moved, x_bump, y_bump;

  pointer_axis_counter #(
    .W(X_W), .MAX(X_MAX), .WRAP(WRAP),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_x_axis (
    .clk(clk), .reset(reset), .control_set(control_set),
    .inc_req(right), .dec_req(left),
    .coord(x_out), .moved(x_moved), .bump(x_bump)
  );

  // Y grows downward on screen.
  pointer_axis_counter #(
    .W(Y_W), .MAX(Y_MAX), .WRAP(WRAP),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_y_axis (
    .clk(clk), .reset(reset), .control_set(control_set),
    .inc_req(down), .dec_req(up),
    .coord(y_out), .moved(y_moved), .bump(y_bump)
  );

  assign moved = x_moved | y_moved;
  assign bump  = x_bump | y_bump;

endmodule

// File: tb/tb_pointer_coord_gen.sv
// Bench for pointer_coord_gen: a wrapping 0..15 instance and a saturating 0..9 instance
// share stimulus; expected outputs are queued per edge and checked by a separate monitor.
module tb_pointer_coord_gen;

  logic clk = 1'b0;
  logic reset, control_set, left, right, up, down;
  logic [3:0] xa, ya, xb, yb;
  logic ma, ba, mb, bb;

  always #5 clk = ~clk;

  pointer_coord_gen dut_a (
    .clk(clk), .reset(reset), .control_set(control_set),
    .left(left), .right(right), .up(up), .down(down),
    .x_out(xa), .y_out(ya), .moved(ma), .bump(ba)
  );

  pointer_coord_gen #(.X_W(4), .Y_W(4), .X_MAX(9), .Y_MAX(9), .WRAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .control_set(control_set),
    .left(left), .right(right), .up(up), .down(down),
    .x_out(xb), .y_out(yb), .moved(mb), .bump(bb)
  );

  typedef struct packed {
    logic [3:0] xa, ya; logic ma, ba;
    logic [3:0] xb, yb; logic mb, bb;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference state: coordinates per instance and last-seen request levels {l,r,u,d}.
  int rxa, rya, rxb, ryb;
  bit [3:0] hist;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void axis(input int v, input bit inc, input bit dec, input int mx,
                               input bit wrap, output int nv, output bit bp);
    nv = v;
    bp = 1'b0;
    if (inc && !dec) begin
      if (v < mx) nv = v + 1; else if (wrap) nv = 0; else bp = 1'b1;
    end else if (dec && !inc) begin
      if (v > 0) nv = v - 1; else if (wrap) nv = mx; else bp = 1'b1;
    end
  endfunction

  // Apply one cycle of inputs, predict the state after the next edge, then wait one cycle.
  task automatic drive(input bit cs, input bit l, input bit r, input bit u, input bit d);
    bit [3:0] lvl, ev;
    int nxa, nya, nxb, nyb;
    bit bxa, bya, bxb, byb;
    exp_t e;
    control_set = cs; left = l; right = r; up = u; down = d;
    lvl  = {l, r, u, d};
    ev   = lvl & ~hist;
    hist = lvl;
    if (cs) begin
      nxa = 0; nya = 0; nxb = 0; nyb = 0;
      bxa = 0; bya = 0; bxb = 0; byb = 0;
    end else begin
      axis(rxa, ev[2], ev[3], 15, 1'b1, nxa, bxa);
      axis(rya, ev[0], ev[1], 15, 1'b1, nya, bya);
      axis(rxb, ev[2], ev[3], 9, 1'b0, nxb, bxb);
      axis(ryb, ev[0], ev[1], 9, 1'b0, nyb, byb);
    end
    e.xa = nxa[3:0]; e.ya = nya[3:0];
    e.ma = !cs && (nxa != rxa || nya != rya);
    e.ba = bxa | bya;
    e.xb = nxb[3:0]; e.yb = nyb[3:0];
    e.mb = !cs && (nxb != rxb || nyb != ryb);
    e.bb = bxb | byb;
    q.push_back(e);
    rxa = nxa; rya = nya; rxb = nxb; ryb = nyb;
    @(posedge clk); #3;
  endtask

  task automatic press(input bit l, input bit r, input bit u, input bit d);
    drive(1'b0, l, r, u, d);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_xa"}, 32'(xa), 0); chk({tag, "_ya"}, 32'(ya), 0);
    chk({tag, "_ma"}, 32'(ma), 0); chk({tag, "_ba"}, 32'(ba), 0);
    chk({tag, "_xb"}, 32'(xb), 0); chk({tag, "_yb"}, 32'(yb), 0);
    chk({tag, "_mb"}, 32'(mb), 0); chk({tag, "_bb"}, 32'(bb), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("x_a", 32'(xa), 32'(e.xa)); chk("y_a", 32'(ya), 32'(e.ya));
        chk("moved_a", 32'(ma), 32'(e.ma)); chk("bump_a", 32'(ba), 32'(e.ba));
        chk("x_b", 32'(xb), 32'(e.xb)); chk("y_b", 32'(yb), 32'(e.yb));
        chk("moved_b", 32'(mb), 32'(e.mb)); chk("bump_b", 32'(bb), 32'(e.bb));
      end
    end
  end

  initial begin : stim
    reset = 1'b1; control_set = 1'b0;
    left = 1'b0; right = 1'b1; up = 1'b0; down = 1'b0;
    rxa = 0; rya = 0; rxb = 0; ryb = 0; hist = 4'hf;
    #2;
    check_zero("reset");
    @(posedge clk); #3;
    reset = 1'b0;

    // Right held through reset release must not step until re-pressed.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    press(0, 1, 0, 0);
    // Walk X to the top: instance A reaches 15 then wraps, B saturates at 9 and bumps.
    for (int i = 0; i < 15; i++) press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    press(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) press(0, 1, 0, 0);
    // Left/right cancel while down steps Y on the same edge.
    drive(0, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 0);
    // control_set wins over a simultaneous press.
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(99) < 3,
            $urandom_range(99) < 35, $urandom_range(99) < 35,
            $urandom_range(99) < 35, $urandom_range(99) < 35);
    end
    for (int i = 0; i < 4; i++) press(0, 0, 1, 1);

    // Asynchronous reset mid-cycle clears outputs without an edge.
    right = 1'b1;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    rxa = 0; rya = 0; rxb = 0; ryb = 0; hist = 4'hf;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    press(0, 0, 1, 0);
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
    end
    drive(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pointer_coord_gen.md
Name: pointer_coord_gen

Overview:
- Two-axis (X/Y) pointer coordinate generator for the on-screen debug pointer.
- Fully synchronous successor of the single-axis Y counter.
- Four direction request lines are edge-detected internally, so one press moves one step.
- Parametrised axis width and bound, with wrap or saturate mode; downstream draw logic consumes the coordinates and a move strobe.

Parameters:
- X_W, 4, X coordinate width in bits
- Y_W, 4, Y coordinate width in bits
- X_MAX, 15, largest legal X value (≤ 2^X_W−1)
- Y_MAX, 15, largest legal Y value (≤ 2^Y_W−1)
- WRAP, 1, 1 = wrap at bounds; 0 = saturate at bounds
- REPEAT_DELAY, 24, cycles a request is held before auto-repeat starts (used only with the optional feature)
- REPEAT_PERIOD, 8, cycles between auto-repeat steps (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- control_set  in  1  synchronous clear of both coordinates to 0
- left  in  1  decrement-X request, level, synchronous to clk
- right  in  1  increment-X request
- up  in  1  decrement-Y request
- down  in  1  increment-Y request
- x_out  out  X_W  current X coordinate
- y_out  out  Y_W  current Y coordinate
- moved  out  1  one-cycle pulse; either coordinate changed this edge
- bump  out  1  one-cycle pulse; a step was blocked at a bound (WRAP=0 only)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - x_out=0, y_out=0, moved=0, bump=0.
  - Request history registers are reset to all 1s, so a button held through reset release produces no move until it is released and pressed again.
  - Optional-feature FSMs reset to IDLE.
- Step event: a request is seen low at clock edge N−1 and high at edge N.
  - The coordinate updates at edge N and is visible after edge N; latency is 1 edge from the first high sample.
  - moved is high for the cycle after edge N.
- Per-axis conflicts:
  - Simultaneous step events on left+right in the same cycle cancel; X is unchanged. Same for up+down on Y.
  - A single level held continuously produces no further steps, unless the optional feature is enabled.
  - X and Y axes are independent; both may step on the same edge, and moved stays a single pulse.
- Increment arithmetic:
  - At value < MAX: value+1.
  - At MAX: 0 if WRAP=1; otherwise hold MAX and assert bump.
- Decrement arithmetic:
  - At value > 0: value−1.
  - At 0: MAX if WRAP=1; otherwise hold 0 and assert bump.
- Out-of-range values: values above MAX are never produced. Non-power-of-two MAX (e.g. 9) wraps at 9, not at 2^W−1.
- control_set:
  - Both coordinates go to 0 on the next edge.
  - Overrides any step events in the same cycle; moved=0, bump=0 that cycle.
  - Request history still samples normally.
- Reset mid-operation: outputs clear immediately, without waiting for an edge. Any in-progress repeat timer is discarded.

Optional Feature:
- POINTER_HOLD_REPEAT_EN defined:
  - Each axis runs an FSM with states IDLE, DELAY, REPEAT.
  - IDLE → DELAY on a step event; the step itself is applied as normal.
  - In DELAY, the counter runs REPEAT_DELAY cycles while the request is held, then issues one step and moves to REPEAT.
  - In REPEAT, one step is issued every REPEAT_PERIOD cycles while the request is held.
  - Release of the request, a conflict (both directions high) or control_set returns the FSM to IDLE.
  - Repeat steps obey the same wrap/saturate, moved and bump rules.
- Macro undefined: no FSM and no timers; exactly one step per press.

Decomposition:
- Shared package pointer_coord_pkg:
  - step-direction enum {STEP_NONE, STEP_INC, STEP_DEC}
  - repeat FSM state enum {RPT_IDLE, RPT_DELAY, RPT_REPEAT}
  - default X_MAX/Y_MAX constants
- Natural sub-module: pointer_axis_counter, instantiated once per axis.
  - It holds edge detect, conflict cancel, bounded wrap/saturate counter and the optional repeat FSM.
  - Parameters are W, MAX, WRAP and the repeat parameters.
  - Top-level ORs the per-axis moved and bump signals.

Test Plan:
- Reset release with right held → x_out stays 0; release, then press right → x_out=1 one edge later, moved pulses once.
- Defaults, WRAP=1, x=15, press right → x=0; y=0, press up → y=15.
- WRAP=0, X_MAX=9, x=9, press right → x stays 9, bump=1 one cycle, moved=0.
- left and right rising on the same edge with x=5 → x stays 5; down rising in that same cycle → y increments, moved=1.
- x=7, y=3, control_set together with a right press → x=0, y=0, moved=0; assert reset mid-cycle → outputs 0 asynchronously.
- With POINTER_HOLD_REPEAT_EN, REPEAT_DELAY=24, REPEAT_PERIOD=8, right held 48 cycles from x=0 → steps at cycles 0, 24, 32, 40, 48, ending at x=5; release → no further steps.
